// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the write-back stage of the five-stage RISC-V core.
package riscv_wb_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int DEFAULT_XLEN = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   rd;
      logic [DEFAULT_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle between execute/memory/decode and the write-back unit.
// The forward ports exist only when WB_BYPASS_EN is defined.
interface writeback_unit_if #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 2
);

   logic                        issue_valid;
   logic [4:0]                  issue_rd;
   logic                        alu_valid;
   logic [4:0]                  alu_rd;
   logic [XLEN-1:0]             alu_data;
   logic                        ld_valid;
   logic                        ld_ready;
   logic [4:0]                  ld_rd;
   logic [XLEN-1:0]             ld_data;
   logic [4:0]                  rs1_addr;
   logic [4:0]                  rs2_addr;
   logic                        rs1_busy;
   logic                        rs2_busy;
   logic                        wb_write_enable;
   logic [4:0]                  wb_addr_rd;
   logic [XLEN-1:0]             wb_data_rd;
   logic [$clog2(LQ_DEPTH):0]   lq_count;
`ifdef WB_BYPASS_EN
   logic                        rs1_fwd_valid;
   logic                        rs2_fwd_valid;
   logic [XLEN-1:0]             rs1_fwd_data;
   logic [XLEN-1:0]             rs2_fwd_data;
`endif

   modport master (
      output issue_valid, issue_rd,
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      output rs1_addr, rs2_addr,
      input  ld_ready, rs1_busy, rs2_busy,
      input  wb_write_enable, wb_addr_rd, wb_data_rd, lq_count
`ifdef WB_BYPASS_EN
      ,
      input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
   );

   modport slave (
      input  issue_valid, issue_rd,
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      input  rs1_addr, rs2_addr,
      output ld_ready, rs1_busy, rs2_busy,
      output wb_write_enable, wb_addr_rd, wb_data_rd, lq_count
`ifdef WB_BYPASS_EN
      ,
      output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
   );

endinterface

// File: rtl/wb_load_fifo.sv
// Circular buffer holding load results waiting for the register file write port.
module wb_load_fifo
   import riscv_wb_pkg::*;
#(
   parameter int  LQ_DEPTH = 2,
   parameter type entry_t  = wb_entry_t,
   localparam int PTR_W    = $clog2(LQ_DEPTH),
   localparam int CNT_W    = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  entry_t           push_entry,
   input  logic             pop,
   output entry_t           head,
   output logic [CNT_W-1:0] count
);

   entry_t           mem [LQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < LQ_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU and load results onto the register file port and
// tracks outstanding destinations for decode stalls. WB_BYPASS_EN adds forwarding.
module writeback_unit
   import riscv_wb_pkg::*;
#(
   parameter int XLEN     = DEFAULT_XLEN,
   parameter int LQ_DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   writeback_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } lq_entry_t;

   lq_entry_t             lq_in;
   lq_entry_t             lq_head;
   logic [CNT_W-1:0]      lq_cnt;
   logic                  lq_push;
   logic                  lq_pop;
   logic                  alu_sel;
   logic                  ld_ready;

   logic                  wb_we_q;
   logic [REG_ADDR_W-1:0] wb_addr_q;
   logic [XLEN-1:0]       wb_data_q;

   logic [31:0]           pending;
   logic [31:0]           pending_next;

   // Ready looks only at occupancy; a same-cycle pop does not open a slot early.
   assign ld_ready = (lq_cnt < DEPTH_C);
   assign lq_in    = '{rd: bus.ld_rd, data: bus.ld_data};
   assign lq_push  = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
   assign alu_sel  = bus.alu_valid && (bus.alu_rd != '0);
   assign lq_pop   = !alu_sel && (lq_cnt != '0);

   wb_load_fifo #(
      .LQ_DEPTH (LQ_DEPTH),
      .entry_t  (lq_entry_t)
   ) u_load_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (lq_push),
      .push_entry (lq_in),
      .pop        (lq_pop),
      .head       (lq_head),
      .count      (lq_cnt)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         wb_we_q <= alu_sel || lq_pop;
         if (alu_sel) begin
            wb_addr_q <= bus.alu_rd;
            wb_data_q <= bus.alu_data;
         end else if (lq_pop) begin
            wb_addr_q <= lq_head.rd;
            wb_data_q <= lq_head.data;
         end
      end
   end

   // Set is applied after clear so a newer producer of the same register wins.
   always_comb begin
      pending_next = pending;
      if (wb_we_q) begin
         pending_next[wb_addr_q] = 1'b0;
      end
      if (bus.issue_valid) begin
         pending_next[bus.issue_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

`ifdef WB_BYPASS_EN
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = wb_we_q && (wb_addr_q == bus.rs1_addr) && (bus.rs1_addr != '0)
                && !(bus.issue_valid && (bus.issue_rd == bus.rs1_addr));
      rs2_hit = wb_we_q && (wb_addr_q == bus.rs2_addr) && (bus.rs2_addr != '0)
                && !(bus.issue_valid && (bus.issue_rd == bus.rs2_addr));
   end

   assign bus.rs1_busy      = pending[bus.rs1_addr] && !rs1_hit;
   assign bus.rs2_busy      = pending[bus.rs2_addr] && !rs2_hit;
   assign bus.rs1_fwd_valid = rs1_hit;
   assign bus.rs2_fwd_valid = rs2_hit;
   assign bus.rs1_fwd_data  = rs1_hit ? wb_data_q : '0;
   assign bus.rs2_fwd_data  = rs2_hit ? wb_data_q : '0;
`else
   assign bus.rs1_busy = pending[bus.rs1_addr];
   assign bus.rs2_busy = pending[bus.rs2_addr];
`endif

   assign bus.ld_ready        = ld_ready;
   assign bus.lq_count        = lq_cnt;
   assign bus.wb_write_enable = wb_we_q;
   assign bus.wb_addr_rd      = wb_addr_q;
   assign bus.wb_data_rd      = wb_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit; forwarding checks compile in with WB_BYPASS_EN.
module tb_writeback_unit;
   import riscv_wb_pkg::*;

   localparam int XLEN     = 32;
   localparam int LQ_DEPTH = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   writeback_unit_if #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) bus ();

   writeback_unit #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic expect_write(logic [4:0] rd, logic [31:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_rd       = '0;
      bus.ld_data     = '0;
   endtask

   task automatic apply_stimulus(logic iv, logic [4:0] ird,
                                 logic av, logic [4:0] ard, logic [31:0] adata,
                                 logic lv, logic [4:0] lrd, logic [31:0] ldata);
      bus.issue_valid = iv;
      bus.issue_rd    = ird;
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_data    = adata;
      bus.ld_valid    = lv;
      bus.ld_rd       = lrd;
      bus.ld_data     = ldata;
   endtask

   // Inputs for a cycle change 1 time unit after its rising edge; checks follow 2 units later.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset_n && bus.wb_write_enable) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got x%0d=0x%08h, expected no write",
                     bus.wb_addr_rd, bus.wb_data_rd);
         end else begin
            e = exp_q.pop_front();
            check_output("wb_addr_rd", 32'(bus.wb_addr_rd), 32'(e.rd));
            check_output("wb_data_rd", bus.wb_data_rd, e.data);
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd0;
      idle_inputs();
      repeat (2) @(posedge clock);
      #3;
      check_output("rst_wb_we",    32'(bus.wb_write_enable), 32'd0);
      check_output("rst_wb_addr",  32'(bus.wb_addr_rd),      32'd0);
      check_output("rst_wb_data",  bus.wb_data_rd,           32'd0);
      check_output("rst_lq_count", 32'(bus.lq_count),        32'd0);
      check_output("rst_ld_ready", 32'(bus.ld_ready),        32'd1);
      check_output("rst_rs1_busy", 32'(bus.rs1_busy),        32'd0);
      reset_n = 1'b1;

      // ALU x5 presented in one cycle, written in the next, strobe lasts one cycle.
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
      expect_write(5'd5, 32'hDEADBEEF);
      #2 check_output("t1_no_early_we", 32'(bus.wb_write_enable), 32'd0);
      next_cycle();
      idle_inputs();
      #2 check_output("t1_we", 32'(bus.wb_write_enable), 32'd1);
      next_cycle();
      #2 check_output("t1_we_one_cycle", 32'(bus.wb_write_enable), 32'd0);

      // Issue x7, then load x7 while the ALU is idle.
      bus.rs1_addr = 5'd7;
      next_cycle();
      apply_stimulus(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2 check_output("t2_busy_before_issue", 32'(bus.rs1_busy), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
      expect_write(5'd7, 32'h1234);
      #2 check_output("t2_busy_issued", 32'(bus.rs1_busy), 32'd1);
      check_output("t2_ld_ready", 32'(bus.ld_ready), 32'd1);
      next_cycle();
      idle_inputs();
      #2 check_output("t2_busy_queued", 32'(bus.rs1_busy), 32'd1);
      check_output("t2_lq_count", 32'(bus.lq_count), 32'd1);
      check_output("t2_no_we_yet", 32'(bus.wb_write_enable), 32'd0);
      next_cycle();
      #2 check_output("t2_we", 32'(bus.wb_write_enable), 32'd1);
`ifdef WB_BYPASS_EN
      check_output("t2_busy_write_cycle", 32'(bus.rs1_busy), 32'd0);
      check_output("t2_fwd_valid", 32'(bus.rs1_fwd_valid), 32'd1);
      check_output("t2_fwd_data", bus.rs1_fwd_data, 32'h1234);
`else
      check_output("t2_busy_write_cycle", 32'(bus.rs1_busy), 32'd1);
`endif
      next_cycle();
      #2 check_output("t2_busy_after", 32'(bus.rs1_busy), 32'd0);

      // Three loads offered under continuous ALU traffic; only two fit.
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd10, 32'hA1A10001, 1'b1, 5'd11, 32'hB0B00001);
      expect_write(5'd10, 32'hA1A10001);
      expect_write(5'd12, 32'hA1A10002);
      expect_write(5'd14, 32'hA1A10003);
      expect_write(5'd11, 32'hB0B00001);
      expect_write(5'd13, 32'hB0B00002);
      #2 check_output("t3_ready_a", 32'(bus.ld_ready), 32'd1);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd12, 32'hA1A10002, 1'b1, 5'd13, 32'hB0B00002);
      #2 check_output("t3_ready_b", 32'(bus.ld_ready), 32'd1);
      check_output("t3_count_b", 32'(bus.lq_count), 32'd1);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd14, 32'hA1A10003, 1'b1, 5'd15, 32'hB0B00003);
      #2 check_output("t3_ready_full", 32'(bus.ld_ready), 32'd0);
      check_output("t3_count_full", 32'(bus.lq_count), 32'd2);
      next_cycle();
      idle_inputs();
      #2 check_output("t3_ready_pop_cycle", 32'(bus.ld_ready), 32'd0);
      check_output("t3_count_pop_cycle", 32'(bus.lq_count), 32'd2);
      next_cycle();
      #2 check_output("t3_ready_after_pop", 32'(bus.ld_ready), 32'd1);
      check_output("t3_count_after_pop", 32'(bus.lq_count), 32'd1);
      next_cycle();
      #2 check_output("t3_count_drained", 32'(bus.lq_count), 32'd0);

      // Everything aimed at x0 is discarded.
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      next_cycle();
      apply_stimulus(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h5555);
      #2 check_output("t4_ready", 32'(bus.ld_ready), 32'd1);
      check_output("t4_rs1_busy", 32'(bus.rs1_busy), 32'd0);
      check_output("t4_rs2_busy", 32'(bus.rs2_busy), 32'd0);
      next_cycle();
      idle_inputs();
      #2 check_output("t4_no_push", 32'(bus.lq_count), 32'd0);
      check_output("t4_no_we", 32'(bus.wb_write_enable), 32'd0);
      next_cycle();
      #2 check_output("t4_no_we_late", 32'(bus.wb_write_enable), 32'd0);

      // Re-issue of x9 on the edge that retires x9 keeps it pending.
      bus.rs2_addr = 5'd9;
      next_cycle();
      apply_stimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
      expect_write(5'd9, 32'h99);
      #2 check_output("t5_busy_issued", 32'(bus.rs2_busy), 32'd1);
      next_cycle();
      apply_stimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2 check_output("t5_we", 32'(bus.wb_write_enable), 32'd1);
      check_output("t5_busy_retarget", 32'(bus.rs2_busy), 32'd1);
`ifdef WB_BYPASS_EN
      check_output("t5_no_fwd_retarget", 32'(bus.rs2_fwd_valid), 32'd0);
`endif
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'h0);
      expect_write(5'd9, 32'hAA);
      #2 check_output("t5_set_wins", 32'(bus.rs2_busy), 32'd1);
      next_cycle();
      idle_inputs();
`ifdef WB_BYPASS_EN
      #2 check_output("t5_busy_fwd", 32'(bus.rs2_busy), 32'd0);
      check_output("t5_fwd_data", bus.rs2_fwd_data, 32'hAA);
`else
      #2 check_output("t5_busy_write_cycle", 32'(bus.rs2_busy), 32'd1);
`endif
      next_cycle();
      #2 check_output("t5_busy_cleared", 32'(bus.rs2_busy), 32'd0);

      // Reset while two loads sit in the queue.
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      expect_write(5'd1, 32'h11);
      expect_write(5'd1, 32'h33);
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 1'b1, 5'd1, 32'h33, 1'b1, 5'd3, 32'h44);
      #2 check_output("t6_count_one", 32'(bus.lq_count), 32'd1);
      next_cycle();
      idle_inputs();
      #2 check_output("t6_count_full", 32'(bus.lq_count), 32'd2);
      check_output("t6_ready_full", 32'(bus.ld_ready), 32'd0);
      #3 reset_n = 1'b0;
      #1 check_output("t6_rst_count", 32'(bus.lq_count), 32'd0);
      check_output("t6_rst_ready", 32'(bus.ld_ready), 32'd1);
      check_output("t6_rst_we", 32'(bus.wb_write_enable), 32'd0);
      @(posedge clock);
      #3 reset_n = 1'b1;
      next_cycle();
      #2 check_output("t6_post_we", 32'(bus.wb_write_enable), 32'd0);
      check_output("t6_post_count", 32'(bus.lq_count), 32'd0);
      next_cycle();
      #2 check_output("t6_post_we_late", 32'(bus.wb_write_enable), 32'd0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clock);
      end
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage for the five-stage RISC-V core. It merges results from the single-cycle ALU path and the variable-latency load path into the register file's single write port. It also keeps a scoreboard of destination registers with writes still outstanding, and answers busy queries from decode for stall generation. It sits between execute/memory and the register file write port (rd address, rd data, write enable).

## Interface
- XLEN, 32, data width
- LQ_DEPTH, 2, load-queue depth; power of two, ≥2
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  an instruction with a destination was issued this cycle
- issue_rd  in  5  its destination register
- alu_valid  in  1  ALU result present; always accepted
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load queue can accept
- ld_rd  in  5  load destination
- ld_data  in  XLEN  load data
- rs1_addr, rs2_addr  in  5 each  decode source queries
- rs1_busy, rs2_busy  out  1 each  source has a pending write
- wb_write_enable  out  1  register file write strobe
- wb_addr_rd  out  5  register file write address
- wb_data_rd  out  XLEN  register file write data
- lq_count  out  $clog2(LQ_DEPTH)+1  load-queue occupancy
- rs1_fwd_valid, rs2_fwd_valid  out  1 each  (WB_BYPASS_EN only) forward hit
- rs1_fwd_data, rs2_fwd_data  out  XLEN each  (WB_BYPASS_EN only) forwarded value

## Operation
- **Reset values.** Reset clears all of the following:
  - pending[31:0], the load queue, wb_write_enable, wb_addr_rd and wb_data_rd all go to 0.
  - lq_count = 0, so ld_ready = 1.
  - Busy and forward outputs read 0.
- **Load queue.**
  - A load result is pushed when ld_valid && ld_ready.
  - ld_ready = (lq_count < LQ_DEPTH). This depends on count only; a pop in the same cycle does not raise ready.
  - A result with ld_rd = 0 is accepted and discarded; it is never pushed.
- **Write selection, once per cycle.**
  - An ALU result with alu_valid && alu_rd != 0 has priority.
  - Otherwise, if the queue is non-empty, the head is popped.
  - Otherwise nothing is written.
  - The selected entry is loaded into the output register. wb_write_enable is high for exactly one cycle per selected entry.
  - An ALU result with alu_rd = 0 is dropped. The queue may pop in that cycle.
- **Starvation.** The ALU has strict priority. The pipeline guarantees an ALU bubble at least once every LQ_DEPTH cycles while loads are queued. The bench must not violate this.
- **Scoreboard.**
  - pending[issue_rd] is set at the edge where issue_valid && issue_rd != 0.
  - pending[wb_addr_rd] is cleared at the edge ending a cycle in which wb_write_enable = 1.
  - If set and clear hit the same index on the same edge, set wins (a newer producer).
  - pending[0] is constant 0.
- **Busy queries.** rsN_busy = pending[rsN_addr] is combinational and is 0 for x0.
- **Simultaneous push and pop** on a non-full queue: count is unchanged and the order is preserved.

## Timing
- ALU result presented in cycle N → wb_write_enable in cycle N+1 → pending cleared from cycle N+2.
- Load pushed at the edge ending cycle N into an empty queue, with no ALU in cycle N+1 → popped in N+1 → wb_write_enable in N+2.
- Queue full: ld_ready is low from the cycle after the filling push until the cycle after a pop.
- reset_n asserted mid-operation: all state clears immediately. In-flight queue entries and the output register are lost, with no partial write. Releasing reset_n is synchronised externally to the clock.

## Configuration
- **With WB_BYPASS_EN defined:** when wb_write_enable && wb_addr_rd == rsN_addr != 0, and issue_valid does not re-target that register in the same cycle:
  - rsN_busy = 0
  - rsN_fwd_valid = 1
  - rsN_fwd_data = wb_data_rd
- **Without the macro:**
  - The forward ports are absent.
  - Busy stays high through the write cycle and drops the following cycle.

## Structure
- The shared package riscv_wb_pkg holds:
  - REG_ADDR_W = 5
  - the XLEN default
  - the wb_entry_t struct {rd[4:0], data[XLEN-1:0]}
- Sub-module wb_load_fifo: a circular buffer of wb_entry_t with push/pop and a count. Pointers wrap modulo LQ_DEPTH.

## Test plan
- ALU x5 = 0xDEADBEEF in cycle 3 → cycle 4: wb_write_enable = 1, wb_addr_rd = 5, wb_data_rd = 0xDEADBEEF.
- issue x7, then load x7 = 0x1234 with the ALU idle → rs1_addr = 7 gives busy = 1 until the write. With bypass: fwd_valid = 1 and fwd_data = 0x1234 in the write cycle. Without bypass: busy = 1 in the write cycle, 0 in the next.
- Three loads offered back-to-back with ALU valid every cycle, LQ_DEPTH = 2 → two are accepted; ld_ready = 0 until the ALU bubble, then the queue drains in FIFO order.
- ALU and load to x0 → no write strobe, no queue push, rs*_busy(0) = 0.
- Same-edge issue x9 and write-back of x9 → pending[9] remains 1.
- reset_n pulsed low with 2 queued loads → lq_count = 0, ld_ready = 1, no write strobe afterward.
